// File: rtl/prom_programmer_pkg.sv
// Shared definitions for the fuse-PROM programming engine.
// Holds the controller state encoding and the error-code values.
// No logic lives here; it is imported by the controller top.
package prom_programmer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BLANK_READ,
    ST_NEXT_BIT,
    ST_SETUP,
    ST_PULSE,
    ST_RECOVER,
    ST_VERIFY,
    ST_FINISH,
    ST_FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE           = 2'd0;
  localparam logic [1:0] ERR_OVERPROGRAMMED = 2'd1;
  localparam logic [1:0] ERR_PULSE_LIMIT    = 2'd2;

endpackage

// File: rtl/prom_programmer_phase_timer.sv
// Load/decrement down-counter shared by the settle, pulse and recover phases.
// Loading N-1 makes a phase last N cycles; expired is high while the count is 0.
// No backpressure: load always wins over the decrement.
module phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Count down to zero after each load, then hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/prom_programmer.sv
// Fuse-PROM programmer: blank-check, per-bit timed burn pulses, read-back verify.
// Latency: SETTLE+2 cycles for an already-matching word, plus one burn sequence per bit.
// start is only sampled in IDLE; requests while busy are dropped.
module prom_programmer
  import prom_programmer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 9,
  parameter int SETTLE_CYCLES  = 50,
  parameter int PULSE_CYCLES   = 5000,
  parameter int RECOVER_CYCLES = 500,
  parameter int MAX_PULSES     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [DATA_WIDTH-1:0]    chip_data_in,
  output logic [ADDRESS_WIDTH-1:0] chip_address_port,
  output logic                     chip_select_n,
  output logic [DATA_WIDTH-1:0]    bit_drive,
  output logic                     program_enable,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               error_code
);

  localparam int MAX_SP  = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_SP > RECOVER_CYCLES) ? MAX_SP : RECOVER_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(DATA_WIDTH + 1);
  localparam int AW      = $clog2(MAX_PULSES + 1);

  localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LOAD   = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] RECOVER_LOAD = TW'(RECOVER_CYCLES - 1);

  state_t                state, nxt;
  logic [DATA_WIDTH-1:0] target, current, bit_mask;
  logic [IW-1:0]         bit_idx;
  logic [AW-1:0]         attempts;
  logic                  tmr_load, tmr_expired;
  logic [TW-1:0]         tmr_value;
  logic                  idx_end, need_burn, bit_ok, over_now, at_limit;

  // Index past the top bit selects nothing, which ends the scan.
  assign idx_end   = (bit_idx == IW'(DATA_WIDTH));
  assign bit_mask  = idx_end ? '0 : (DATA_WIDTH'(1) << bit_idx);
  assign need_burn = |(target & ~current & bit_mask);
  assign bit_ok    = |(chip_data_in & bit_mask);
  assign over_now  = |(chip_data_in & ~target);
  assign at_limit  = (attempts == AW'(MAX_PULSES));

  phase_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Next-state decode; each timed phase reloads the timer on entry.
  always_comb begin
    nxt       = state;
    tmr_load  = 1'b0;
    tmr_value = SETTLE_LOAD;
    case (state)
      ST_IDLE: if (start) begin
        nxt = ST_BLANK_READ; tmr_load = 1'b1;
      end
      ST_BLANK_READ: if (tmr_expired) begin
        if (over_now)                    nxt = ST_FAIL;
        else if (chip_data_in == target) nxt = ST_FINISH;
        else                             nxt = ST_NEXT_BIT;
      end
      ST_NEXT_BIT: begin
        if (idx_end) begin
          nxt = ST_FINISH;
        end else if (need_burn) begin
          nxt = ST_SETUP; tmr_load = 1'b1;
        end
      end
      ST_SETUP: if (tmr_expired) begin
        nxt = ST_PULSE; tmr_load = 1'b1; tmr_value = PULSE_LOAD;
      end
      ST_PULSE: if (tmr_expired) begin
        nxt = ST_RECOVER; tmr_load = 1'b1; tmr_value = RECOVER_LOAD;
      end
      ST_RECOVER: if (tmr_expired) begin
        nxt = ST_VERIFY; tmr_load = 1'b1;
      end
      ST_VERIFY: if (tmr_expired) begin
        if (over_now)      nxt = ST_FAIL;
        else if (bit_ok)   nxt = ST_NEXT_BIT;
        else if (at_limit) nxt = ST_FAIL;
        else begin
          nxt = ST_SETUP; tmr_load = 1'b1;
        end
      end
      ST_FINISH: nxt = ST_IDLE;
      ST_FAIL:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered chip/handshake outputs; pin outputs follow nxt so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chip_address_port <= '0;
      target            <= '0;
      current           <= '0;
      bit_idx           <= '0;
      attempts          <= '0;
      error_code        <= ERR_NONE;
      chip_select_n     <= 1'b1;
      bit_drive         <= '0;
      program_enable    <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          chip_address_port <= address_in;
          target            <= data_in;
          current           <= '0;
          bit_idx           <= '0;
          error_code        <= ERR_NONE;
        end
        ST_BLANK_READ: if (tmr_expired) begin
          current <= chip_data_in;
          if (over_now) error_code <= ERR_OVERPROGRAMMED;
        end
        ST_NEXT_BIT: begin
          if (need_burn)     attempts <= '0;
          else if (!idx_end) bit_idx  <= bit_idx + 1'b1;
        end
        ST_PULSE: if (tmr_expired) attempts <= attempts + 1'b1;
        ST_VERIFY: if (tmr_expired) begin
          if (over_now) begin
            error_code <= ERR_OVERPROGRAMMED;
          end else if (bit_ok) begin
            current <= chip_data_in;
            bit_idx <= bit_idx + 1'b1;
          end else if (at_limit) begin
            error_code <= ERR_PULSE_LIMIT;
          end
        end
        default: ;
      endcase
      chip_select_n  <= !(nxt == ST_BLANK_READ || nxt == ST_VERIFY);
      bit_drive      <= (nxt == ST_SETUP || nxt == ST_PULSE) ? bit_mask : '0;
      program_enable <= (nxt == ST_PULSE);
      busy           <= (nxt != ST_IDLE);
      done           <= (state == ST_FINISH);
      error          <= (state == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_prom_programmer.sv
module tb_prom_programmer;

  localparam int DW = 8, AWD = 9, SETTLE = 3, PULSE = 10, RECOVER = 4, MAXP = 3;

  logic           clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [AWD-1:0] address_in = '0;
  logic [DW-1:0]  data_in = '0;
  logic [DW-1:0]  chip_data_in;
  logic [AWD-1:0] chip_address_port;
  logic           chip_select_n, program_enable, busy, done, error;
  logic [DW-1:0]  bit_drive;
  logic [1:0]     error_code;

  prom_programmer #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AWD), .SETTLE_CYCLES(SETTLE),
    .PULSE_CYCLES(PULSE), .RECOVER_CYCLES(RECOVER), .MAX_PULSES(MAXP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .address_in(address_in), .data_in(data_in),
    .chip_data_in(chip_data_in), .chip_address_port(chip_address_port),
    .chip_select_n(chip_select_n), .bit_drive(bit_drive), .program_enable(program_enable),
    .busy(busy), .done(done), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_err;
    logic [1:0] code;
    int       pulses;
    logic [7:0] final_v;
    logic [8:0] addr;
    int       lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_drv[$];
  logic [7:0] mem [0:511];
  logic [7:0] stuck = '0;
  logic [7:0] junk = '0;
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, t0 = 0, pw = 0, pulse_cnt = 0;
  logic [7:0] drv_seen = '0;
  bit rst_test = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: reads the fuse array only while selected, garbage otherwise.
  always @(negedge clk) junk <= 8'($urandom);
  assign chip_data_in = chip_select_n ? junk : mem[chip_address_port];

  // Chip model: a full-width pulse blows the driven fuse unless it is stuck.
  always @(negedge clk) begin
    if (program_enable) begin
      pw++;
      drv_seen = bit_drive;
    end else if (pw > 0) begin
      chk("pulse_width_max", 32'(pw <= PULSE), 32'd1);
      if (!rst_test) begin
        chk("pulse_width", pw, PULSE);
        if (exp_drv.size() == 0) chk("unexpected_pulse", drv_seen, 0);
        else chk("pulse_bit_drive", drv_seen, exp_drv.pop_front());
      end
      if (pw == PULSE) mem[chip_address_port] = mem[chip_address_port] | (drv_seen & ~stuck);
      pulse_cnt++;
      pw = 0;
    end
  end

  // Monitor: every done/error is matched against the oldest prediction.
  always @(negedge clk) begin
    if (!reset && (done || error)) begin
      if (sb.size() == 0) begin
        chk("unexpected_response", {30'd0, done, error}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("outcome_is_error", 32'(error), 32'(e.is_err));
        chk("outcome_done", 32'(done), 32'(!e.is_err));
        chk("error_code", error_code, e.code);
        chk("pulse_count", pulse_cnt, e.pulses);
        chk("cell_value", mem[e.addr], e.final_v);
        if (e.lat >= 0) chk("done_latency", cyc - t0 + 1, e.lat);
      end
      pulse_cnt = 0;
    end
  end

  // Reference model: what the word programming should achieve, bit by bit.
  task automatic predict(input logic [8:0] a, input logic [7:0] c, input logic [7:0] t,
                         input logic [7:0] s);
    exp_t e;
    logic [7:0] v;
    v = c;
    e.addr = a; e.lat = -1; e.pulses = 0; e.is_err = 0; e.code = 2'd0;
    if ((c & ~t) != 0) begin
      e.is_err = 1; e.code = 2'd1;
    end else if (c == t) begin
      e.lat = SETTLE + 2;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (t[b] && !c[b]) begin
          if (s[b]) begin
            for (int k = 0; k < MAXP; k++) exp_drv.push_back(8'(1 << b));
            e.pulses += MAXP; e.is_err = 1; e.code = 2'd2;
            break;
          end
          exp_drv.push_back(8'(1 << b));
          e.pulses++;
          v[b] = 1'b1;
        end
      end
    end
    e.final_v = v;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk("response_timeout", sb.size(), 0);
      sb.delete();
      exp_drv.delete();
    end
  endtask

  task automatic issue(input logic [8:0] a, input logic [7:0] t);
    @(negedge clk);
    address_in = a; data_in = t; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    address_in = 9'($urandom); data_in = 8'($urandom);
    chk("busy_after_start", busy, 1);
    chk("address_with_busy", chip_address_port, a);
  endtask

  task automatic run_txn(input logic [8:0] a, input logic [7:0] c, input logic [7:0] t,
                         input logic [7:0] s);
    mem[a] = c; stuck = s;
    predict(a, c, t, s);
    issue(a, t);
    wait_empty(2000);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_program_enable"}, program_enable, 0);
    chk({tag, "_bit_drive"}, bit_drive, 0);
    chk({tag, "_chip_select_n"}, chip_select_n, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done_error"}, {done, error}, 0);
    chk({tag, "_error_code"}, error_code, 0);
    chk({tag, "_address"}, chip_address_port, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] c, t, s;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    #1 reset = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Already programmed word: no pulses, done at SETTLE+2.
    run_txn(9'h1FF, 8'h5A, 8'h5A, 8'h00);
    // Full burn from blank.
    run_txn(9'h010, 8'h00, 8'hA5, 8'h00);
    chk("full_burn_readback", mem[9'h010], 8'hA5);
    // Overprogrammed cell.
    run_txn(9'h020, 8'h81, 8'h01, 8'h00);
    // Pulse limit on a bit that never fuses.
    run_txn(9'h030, 8'h00, 8'h08, 8'h08);
    @(negedge clk);
    chk("idle_after_limit", busy, 0);

    // Reset during the fifth cycle of a pulse.
    mem[9'h040] = 8'h00; stuck = 8'h00; rst_test = 1;
    issue(9'h040, 8'h02);
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < 200 && hi < 5; i++) begin
        @(negedge clk);
        if (program_enable) hi++;
      end
      chk("pulse_reached", hi, 5);
    end
    #1 reset = 1'b1;
    #1 chk_reset_outputs("mid_pulse_reset");
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_response_after_reset", sb.size(), 0);
    pulse_cnt = 0; rst_test = 0;

    // Start while busy is ignored, even with changed address/data.
    mem[9'h050] = 8'h00; mem[9'h051] = 8'h00; stuck = 8'h00;
    predict(9'h050, 8'h00, 8'hF0, 8'h00);
    issue(9'h050, 8'hF0);
    repeat (5) @(negedge clk);
    address_in = 9'h051; data_in = 8'h0F; start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_empty(2000);
    chk("busy_start_other_cell", mem[9'h051], 8'h00);
    chk("busy_start_cell", mem[9'h050], 8'hF0);

    // Randomized words against the reference model.
    for (int n = 0; n < 30; n++) begin
      t = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       c = t;
        1:       c = 8'($urandom);
        default: c = t & 8'($urandom);
      endcase
      s = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run_txn(9'($urandom), c, t, s);
    end

    repeat (10) @(negedge clk);
    chk("leftover_pulses", exp_drv.size(), 0);
    chk("leftover_responses", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prom_programmer.md
# prom_programmer

Fuse-PROM programming engine for the IP3604 (512x8) and IP3601 (256x4) chips. It is the write-side counterpart of `rom_reader`. It takes one address/data word per `start` request and blank-checks the cell. It then burns each required bit with timed programming pulses and verifies every bit by read-back. It sits between the board top level (buttons, UART or host loader) and the chip GPIO, sharing the address and data pins with the reader through an external mux.

## Interface
- `DATA_WIDTH`, 8: word width (4 for IP3601).
- `ADDRESS_WIDTH`, 9: address width (8 for IP3601).
- `SETTLE_CYCLES`, 50: address/bit setup and read-settle time, in clk cycles, ≥1.
- `PULSE_CYCLES`, 5000: programming pulse width in clk cycles, ≥1.
- `RECOVER_CYCLES`, 500: cool-down after each pulse, ≥1.
- `MAX_PULSES`, 8: pulse attempts allowed per bit before failure, ≥1.

Ports:
- `clk` in 1: board clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `address_in` in ADDRESS_WIDTH: target address, latched on accepted `start`.
- `data_in` in DATA_WIDTH: target word, latched on accepted `start` (1 = bit to burn).
- `chip_data_in` in DATA_WIDTH: chip data outputs.
- `chip_address_port` out ADDRESS_WIDTH: address driven to the chip.
- `chip_select_n` out 1: chip enable, active-low.
- `bit_drive` out DATA_WIDTH: one-hot output-pin select for the pulse.
- `program_enable` out 1: gates the external Vpp switch.
- `busy` out 1: high from the accepted `start` until return to IDLE.
- `done` out 1: one-cycle pulse when a word is successfully programmed.
- `error` out 1: one-cycle pulse on failure, together with `error_code`.
- `error_code` out 2: 0 none, 1 overprogrammed, 2 pulse limit; held until the next accepted `start`.

## Operation
- **Reset values:** all outputs 0 except `chip_select_n` = 1; state IDLE.
- **IDLE:** `start`=1 latches `address_in` and `data_in`, clears `error_code` and the bit index, sets `busy`, and goes to BLANK_READ.
- **BLANK_READ:**
  - Drive the address with `chip_select_n`=0 and wait SETTLE_CYCLES.
  - Sample `chip_data_in` into `current` on the last settle cycle.
  - If `current & ~target` ≠ 0, go to FAIL with code 1.
  - If `current == target`, go to FINISH with no pulses.
  - Otherwise go to NEXT_BIT.
- **NEXT_BIT:**
  - Scan from the current index upward for the first bit with target=1 and current=0.
  - The scan is done one bit per cycle.
  - If none is left, go to FINISH; else clear the attempt counter and go to SETUP.
- **SETUP:** `bit_drive` = one-hot(index) and `chip_select_n`=1. Wait SETTLE_CYCLES.
- **PULSE:** `program_enable`=1 for exactly PULSE_CYCLES, then increment attempts.
- **RECOVER:** `program_enable`=0 and `bit_drive`=0 for RECOVER_CYCLES.
- **VERIFY:**
  - `chip_select_n`=0; wait SETTLE_CYCLES and sample.
  - If the bit reads 1: update `current`, index+1, go to NEXT_BIT.
  - Else if attempts == MAX_PULSES: go to FAIL with code 2.
  - Else go back to SETUP.
- **Overprogramming check:** VERIFY also applies the BLANK_READ check (code 1) to all bits.
- **FINISH:** `done`=1 for one cycle, then IDLE.
- **FAIL:** `error`=1 for one cycle, then IDLE.
- **Outside the active states:** `program_enable` and `bit_drive` are registered and are 0 in every state other than PULSE (`program_enable`) and SETUP/PULSE (`bit_drive`).
- **Widths:** the attempt counter is `$clog2(MAX_PULSES+1)` bits wide. The timer is sized to the maximum of the three cycle parameters.

## Timing
- `start` to `busy`=1 takes 1 cycle; `chip_address_port` is valid in the same cycle as `busy`.
- **Blank word already matching:** `done` asserts SETTLE_CYCLES+2 cycles after `start`.
- **Cost of one burned bit (first-try success):** SETTLE + PULSE + RECOVER + SETTLE cycles, plus up to DATA_WIDTH scan cycles.
- **`start` while busy:** ignored. `start` held high re-triggers after IDLE is re-entered.
- **Reset at any time, including mid-PULSE:** `program_enable` and `bit_drive` drop to 0 asynchronously. No pulse ever exceeds PULSE_CYCLES.
- **Input changes:** `chip_data_in` is used only at the sample cycle. Changes to `address_in`/`data_in` while busy have no effect.

## Structure
- **Shared package `prom_programmer_pkg`:** state encoding (IDLE, BLANK_READ, NEXT_BIT, SETUP, PULSE, RECOVER, VERIFY, FINISH, FAIL) and the error-code constants `ERR_NONE`, `ERR_OVERPROGRAMMED`, `ERR_PULSE_LIMIT`.
- **Sub-module `phase_timer`:** a load/decrement down-counter with a `expired` flag, shared by the settle, pulse and recover phases.

## Test plan
Bench parameters: SETTLE=3, PULSE=10, RECOVER=4, MAX_PULSES=3, 8-bit word.
1. **Already programmed:** blank model reads 0x5A, program 0x5A at 0x1FF → `done` at cycle 5, `program_enable` never high, `error_code`=0.
2. **Full burn:** model reads 0x00 and sets a bit after its first pulse; program 0xA5 at 0x010 → exactly 4 pulses, on `bit_drive` 0x01, 0x04, 0x20, 0x80, each 10 cycles. Then `done` follows and the model reads 0xA5.
3. **Overprogrammed:** model reads 0x81, program 0x01 → `error`, `error_code`=1, zero pulses.
4. **Pulse limit:** model bit 3 never fuses, program 0x08 → 3 pulses, then `error_code`=2 and IDLE.
5. **Reset mid-pulse:** assert `reset` at cycle 5 of a PULSE → `program_enable`=0 within the same cycle, and all outputs return to their reset values.
6. **Start ignored while busy:** `start` with 0x0F while busy programming 0xF0 → only 0xF0 is programmed, with one `done`.
